fifo_frame_parser: RTL and testbench
====================================

# fifo_frame_parser

Frame parser on the read side of the asynchronous FIFO, in the `out_clk` domain. It drains bytes from the FIFO read port and splits the stream into length-prefixed frames: length byte, payload, checksum. Payload goes out on a valid/ready stream with a last marker. Per-frame status pulses and saturating frame/error counters go to monitoring logic.

## Interface
- `WIDTH`, default 8: data width; matches the FIFO `WIDTH`.
- `MAX_LEN`, default 16: largest accepted payload length, range 1..2^WIDTH-1.
- `out_clk`  in  1  clock, shared with the FIFO read side.
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `fifo_e`  in  1  FIFO empty flag.
- `fifo_data`  in  WIDTH  FIFO read data; valid the cycle after a `fifo_rd` strobe.
- `fifo_rd`  out  1  read strobe; drives the FIFO `out_ready`.
- `m_data`  out  WIDTH  payload byte.
- `m_valid`  out  1  `m_data` valid.
- `m_ready`  in  1  downstream accept.
- `m_last`  out  1  marks the final payload byte of a frame; qualified by `m_valid`.
- `frame_done`  out  1  one-cycle pulse at the end of each parsed frame.
- `frame_err`  out  1  one-cycle pulse on a bad checksum, zero length or oversize length.
- `frame_count`  out  16  count of good frames; saturates at 0xFFFF.
- `err_count`  out  16  count of errored frames; saturates at 0xFFFF.

## Operation
- Byte register `byte_q`/`byte_v` holds one FIFO byte.
- `rd_pend` is `fifo_rd` registered. When `rd_pend`=1, `byte_q` loads `fifo_data` and `byte_v` is set.
- `fifo_rd` = !`fifo_e` & !`rd_pend` & (!`byte_v` | `take`). `take` means the byte is consumed this cycle.
- States:
  - **LEN**: consumes a byte unconditionally.
    - L=0: `frame_err` pulse, `err_count`+1, stay in LEN.
    - L>`MAX_LEN`: `frame_err` pulse, `err_count`+1, go to DISCARD with `remain`=L+1.
    - Otherwise: `sum`=L, `remain`=L, go to PAYLOAD.
  - **PAYLOAD**: `m_valid`=`byte_v`, `m_data`=`byte_q`, `m_last`=(`remain`==1).
    - `take`=`m_valid`&`m_ready`.
    - On take: `sum`+=byte, `remain`-1. When `remain` was 1, go to CHECK.
  - **CHECK**: consumes a byte unconditionally.
    - Always: `frame_done` pulse.
    - byte==`sum`: `frame_count`+1.
    - Otherwise: `frame_err` pulse, `err_count`+1.
    - Go to LEN.
  - **DISCARD**: consumes bytes with no output. `remain`-1 per byte; on the last byte go to LEN. No `frame_done`.
- `sum` is WIDTH bits, modulo 2^WIDTH. `remain` is WIDTH+1 bits.
- `m_valid` is 0 outside PAYLOAD. `m_data` is don't-care when `m_valid`=0.
- Backpressure: while `m_valid`&!`m_ready`, `m_data`, `m_last` and `byte_q` hold, and no new read is issued.
- Counters saturate and never wrap.
- FIFO empty: no read is issued and the state holds indefinitely. There is no timeout.
- Reset asserted at any point (including mid-frame): state LEN, `byte_v`=0, `rd_pend`=0, `sum`=0, `remain`=0, counters 0. The FIFO byte arriving the cycle after reset is dropped.

## Timing
- Reset values: `fifo_rd`=0, `m_valid`=0, `m_last`=0, `m_data`=0, `frame_done`=0, `frame_err`=0, `frame_count`=0, `err_count`=0.
- Read latency:
  - `fifo_rd` high in cycle t.
  - `fifo_data` sampled at the end of t+1.
  - `byte_v`=1 in t+2.
  - Earliest `m_valid` is t+2.
- Peak throughput is 1 byte per 2 cycles: with `take` in t+2, the next `fifo_rd` is also in t+2.
- At most one read is outstanding, so the FIFO is never over-read beyond its own `fifo_e` guard.
- `frame_done`/`frame_err` pulse in the cycle the checksum (or bad length) byte is consumed. Counters update on the next edge.
- `m_last` is high together with the final payload `m_valid`, not after it.

## Structure
- Shared package `fifo_frame_pkg`:
  - state encoding LEN/PAYLOAD/CHECK/DISCARD;
  - counter width 16;
  - counter saturation constant.
- One sub-module: `sat_counter16` (increment-enable, saturating), instantiated twice.
- The FSM, byte register and read control stay in `fifo_frame_parser`.

## Test plan
- Good frame:
  - Stimulus: bytes 03,10,20,30,63 with `m_ready`=1.
  - Response: `m_data` 10,20,30, `m_last` on 30; `frame_done` one pulse, `frame_err` 0, `frame_count`=1.
- Bad checksum:
  - Stimulus: bytes 03,10,20,30,64.
  - Response: payload still output; `frame_done` and `frame_err` pulse together; `err_count`=1, `frame_count` unchanged.
- Zero and oversize length, with `MAX_LEN`=4:
  - Stimulus: bytes 00 then 06,01..06,AA then 01,55,56.
  - Response: two `frame_err` pulses; no `m_valid` for the first two frames; then `m_data`=55 with `m_last`; `frame_count`=1, `err_count`=2.
- Backpressure:
  - Stimulus: good frame with `m_ready`=0 for 5 cycles on the second payload byte.
  - Response: `m_data`=20 held stable; `fifo_rd` stays 0 throughout the stall; the frame completes correctly.
- Reset mid-frame:
  - Stimulus: `reset` asserted after payload byte 10 of frame 03,10,20,30,63; then clean frame 01,7F,80.
  - Response: all outputs and counters 0; then `m_data`=7F with `m_last`, `frame_count`=1.
- Empty FIFO and throughput:
  - Stimulus: `fifo_e` held 1, then a burst of 5 bytes.
  - Response: `fifo_rd` stays 0 while empty; during the burst, consecutive `fifo_rd` strobes are exactly 2 cycles apart.

Source files
------------

// File: rtl/fifo_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fifo_frame_pkg
// Brief   : Shared types and constants for the FIFO frame parser.
// Revision: 1.0
// ============================================================================
package fifo_frame_pkg;

    typedef enum logic [1:0] {
        ST_LEN     = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2,
        ST_DISCARD = 2'd3
    } state_t;

    localparam int                 c_cnt_w   = 16;
    localparam logic [c_cnt_w-1:0] c_cnt_max = {c_cnt_w{1'b1}};

endpackage
`default_nettype wire

// File: rtl/sat_counter16.sv
`default_nettype none
// ============================================================================
// Module  : sat_counter16
// Brief   : Increment-enable counter that sticks at its maximum value.
// Revision: 1.0
// ============================================================================
module sat_counter16
    import fifo_frame_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_inc,
    output logic [c_cnt_w-1:0] o_count
);

    logic [c_cnt_w-1:0] count_q;
    logic [c_cnt_w-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_inc && (count_q != c_cnt_max)) begin
            count_d = count_q + c_cnt_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;

endmodule
`default_nettype wire

// File: rtl/fifo_frame_parser.sv
`default_nettype none
// ============================================================================
// Module  : fifo_frame_parser
// Brief   : Splits the FIFO byte stream into length/payload/checksum frames.
// Revision: 1.0
// ============================================================================
module fifo_frame_parser
    import fifo_frame_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MAX_LEN = 16
) (
    input  logic               out_clk,
    input  logic               reset,
    input  logic               fifo_e,
    input  logic [WIDTH-1:0]   fifo_data,
    output logic               fifo_rd,
    output logic [WIDTH-1:0]   m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               m_last,
    output logic               frame_done,
    output logic               frame_err,
    output logic [c_cnt_w-1:0] frame_count,
    output logic [c_cnt_w-1:0] err_count
);

    localparam logic [WIDTH-1:0] c_max_len = WIDTH'(MAX_LEN);
    localparam logic [WIDTH:0]   c_one_r   = (WIDTH+1)'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] byte_q, byte_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH:0]   remain_q, remain_d;
    logic             byte_v_q, byte_v_d;
    logic             rd_pend_q, rd_pend_d;

    logic w_in_payload;
    logic w_last;
    logic w_take;
    logic w_done;
    logic w_err;
    logic w_good;

    assign w_in_payload = (state_q == ST_PAYLOAD);
    assign w_last       = (remain_q == c_one_r);
    // Only the payload state waits on the consumer; every other state eats its byte.
    assign w_take       = byte_v_q & (!w_in_payload | m_ready);
    assign fifo_rd      = !reset & !fifo_e & !rd_pend_q & (!byte_v_q | w_take);

    always_comb begin
        state_d  = state_q;
        sum_d    = sum_q;
        remain_d = remain_q;
        w_done   = 1'b0;
        w_err    = 1'b0;
        w_good   = 1'b0;
        if (w_take) begin
            case (state_q)
                ST_LEN: begin
                    if (byte_q == '0) begin
                        w_err = 1'b1;
                    end else if (byte_q > c_max_len) begin
                        w_err    = 1'b1;
                        remain_d = {1'b0, byte_q} + c_one_r;
                        state_d  = ST_DISCARD;
                    end else begin
                        sum_d    = byte_q;
                        remain_d = {1'b0, byte_q};
                        state_d  = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    sum_d    = sum_q + byte_q;
                    remain_d = remain_q - c_one_r;
                    if (w_last) begin
                        state_d = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    w_done  = 1'b1;
                    w_good  = (byte_q == sum_q);
                    w_err   = (byte_q != sum_q);
                    state_d = ST_LEN;
                end
                ST_DISCARD: begin
                    remain_d = remain_q - c_one_r;
                    if (w_last) begin
                        state_d = ST_LEN;
                    end
                end
                default: state_d = ST_LEN;
            endcase
        end
    end

    always_comb begin
        byte_d    = byte_q;
        byte_v_d  = byte_v_q;
        rd_pend_d = fifo_rd;
        if (rd_pend_q) begin
            byte_d   = fifo_data;
            byte_v_d = 1'b1;
        end else if (w_take) begin
            byte_v_d = 1'b0;
        end
    end

    always_ff @(posedge out_clk) begin
        if (reset) begin
            state_q   <= ST_LEN;
            byte_q    <= '0;
            byte_v_q  <= 1'b0;
            rd_pend_q <= 1'b0;
            sum_q     <= '0;
            remain_q  <= '0;
        end else begin
            state_q   <= state_d;
            byte_q    <= byte_d;
            byte_v_q  <= byte_v_d;
            rd_pend_q <= rd_pend_d;
            sum_q     <= sum_d;
            remain_q  <= remain_d;
        end
    end

    assign m_valid    = w_in_payload & byte_v_q;
    assign m_data     = byte_q;
    assign m_last     = w_in_payload & w_last;
    assign frame_done = w_done;
    assign frame_err  = w_err;

    sat_counter16 u_good_cnt (
        .clk     (out_clk),
        .rst     (reset),
        .i_inc   (w_good),
        .o_count (frame_count)
    );

    sat_counter16 u_err_cnt (
        .clk     (out_clk),
        .rst     (reset),
        .i_inc   (w_err),
        .o_count (err_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_fifo_frame_parser.sv
`default_nettype none
// ============================================================================
// Module  : tb_fifo_frame_parser
// Brief   : Randomized self-checking bench with a frame-level reference model.
// Revision: 1.0
// ============================================================================
module tb_fifo_frame_parser;

    localparam int WIDTH   = 8;
    localparam int MAX_LEN = 4;

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic        fifo_e     = 1'b1;
    logic [7:0]  fifo_data  = 8'h00;
    logic        m_ready    = 1'b0;
    logic        fifo_rd;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_last;
    logic        frame_done;
    logic        frame_err;
    logic [15:0] frame_count;
    logic [15:0] err_count;

    fifo_frame_parser #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
        .out_clk     (clk),
        .reset       (reset),
        .fifo_e      (fifo_e),
        .fifo_data   (fifo_data),
        .fifo_rd     (fifo_rd),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_last      (m_last),
        .frame_done  (frame_done),
        .frame_err   (frame_err),
        .frame_count (frame_count),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // FIFO model: a queue popped on the edge after a sampled read strobe.
    logic [7:0] fq[$];
    logic       rd_s       = 1'b0;
    logic       hold_empty = 1'b0;

    initial forever begin
        @(posedge clk);
        #1;
        if (rd_s && fq.size() > 0) fifo_data = fq.pop_front();
        fifo_e = hold_empty || (fq.size() == 0);
    end

    // Reference model state: expected beats and frame-level tallies.
    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } beat_t;

    beat_t      exp_q[$];
    int         exp_good = 0;
    int         exp_err  = 0;
    int         exp_done = 0;
    int         done_seen = 0;
    int         err_seen  = 0;
    logic [7:0] frm[$];

    task automatic send_frame();
        int         len;
        logic [7:0] s;
        beat_t      bt;
        len = int'(frm[0]);
        foreach (frm[i]) fq.push_back(frm[i]);
        if (len == 0 || len > MAX_LEN) begin
            exp_err++;
        end else begin
            s = frm[0];
            for (int i = 1; i <= len; i++) begin
                bt.d = frm[i];
                bt.l = (i == len);
                exp_q.push_back(bt);
                s = s + frm[i];
            end
            exp_done++;
            if (frm[len+1] == s) exp_good++;
            else exp_err++;
        end
    endtask

    task automatic make_frame(input int len, input bit good);
        logic [7:0] s;
        logic [7:0] b;
        s = 8'(len);
        frm.delete();
        frm.push_back(8'(len));
        if (len != 0) begin
            for (int i = 0; i < len; i++) begin
                b = 8'($urandom);
                frm.push_back(b);
                s = s + b;
            end
            frm.push_back(good ? s : (s ^ 8'($urandom_range(1, 255))));
        end
    endtask

    // Output monitor on the falling edge, away from the active edge.
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data = 8'h00;
    logic       stall_last = 1'b0;

    initial forever begin
        beat_t e;
        @(negedge clk);
        rd_s = fifo_rd;
        if (fifo_rd) chk("no_overread", fifo_e, 1'b0);
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("bp_valid", m_valid, 1'b1);
                chk("bp_data", m_data, stall_data);
                chk("bp_last", m_last, stall_last);
            end
            if (m_valid && !m_ready) chk("stall_no_rd", fifo_rd, 1'b0);
            stall_prev = m_valid && !m_ready;
            stall_data = m_data;
            stall_last = m_last;
            if (m_valid && m_ready) begin
                chk("beat_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("beat_data", m_data, e.d);
                    chk("beat_last", m_last, e.l);
                end
            end
            if (frame_done) done_seen++;
            if (frame_err)  err_seen++;
        end
    end

    task automatic drain(input bit rand_ready);
        int n;
        n = 0;
        while ((fq.size() != 0 || exp_q.size() != 0) && n < 3000) begin
            @(posedge clk);
            #1;
            m_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            n++;
        end
        m_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("drain_in_time", 32'(n < 3000), 1);
        chk("exp_empty", exp_q.size(), 0);
    endtask

    task automatic check_counts(input string tag);
        chk({tag, "_frame_count"}, frame_count, exp_good);
        chk({tag, "_err_count"}, err_count, exp_err);
        chk({tag, "_done_pulses"}, done_seen, exp_done);
        chk({tag, "_err_pulses"}, err_seen, exp_err);
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_fifo_rd"}, fifo_rd, 1'b0);
        chk({tag, "_m_valid"}, m_valid, 1'b0);
        chk({tag, "_m_last"}, m_last, 1'b0);
        chk({tag, "_m_data"}, m_data, 8'h00);
        chk({tag, "_frame_done"}, frame_done, 1'b0);
        chk({tag, "_frame_err"}, frame_err, 1'b0);
        chk({tag, "_frame_count"}, frame_count, 16'h0);
        chk({tag, "_err_count"}, err_count, 16'h0);
    endtask

    initial begin
        int  strobes[$];
        bit  found;

        // Power-on reset
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle_zero("reset");
        reset   = 1'b0;
        m_ready = 1'b1;

        // Good frame, then bad checksum
        frm = '{8'h03, 8'h10, 8'h20, 8'h30, 8'h63};
        send_frame();
        drain(1'b0);
        check_counts("good");

        frm = '{8'h03, 8'h10, 8'h20, 8'h30, 8'h64};
        send_frame();
        drain(1'b0);
        check_counts("badsum");

        // Zero length, oversize length, then a one-byte frame
        frm = '{8'h00};
        send_frame();
        frm = '{8'h06, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'hAA};
        send_frame();
        frm = '{8'h01, 8'h55, 8'h56};
        send_frame();
        drain(1'b0);
        check_counts("lenerr");

        // Backpressure on the second payload byte
        frm = '{8'h03, 8'h10, 8'h20, 8'h30, 8'h63};
        send_frame();
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(posedge clk);
            #1;
            if (m_valid && m_data == 8'h20) found = 1'b1;
        end
        chk("bp_reached", found, 1'b1);
        m_ready = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("bp_hold_data", m_data, 8'h20);
            chk("bp_hold_rd", fifo_rd, 1'b0);
        end
        m_ready = 1'b1;
        drain(1'b0);
        check_counts("bp");

        // Randomized frames with random backpressure
        for (int f = 0; f < 40; f++) begin
            make_frame($urandom_range(0, 6), $urandom_range(0, 3) != 0);
            send_frame();
        end
        drain(1'b1);
        check_counts("rand");

        // Empty FIFO holds off reads; then a burst at full rate
        hold_empty = 1'b1;
        frm = '{8'h03, 8'h01, 8'h02, 8'h03, 8'h09};
        send_frame();
        repeat (12) begin
            @(posedge clk);
            #1;
            chk("empty_no_rd", fifo_rd, 1'b0);
        end
        @(negedge clk);
        hold_empty = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (fifo_rd) strobes.push_back(c);
        end
        chk("burst_strobes", strobes.size(), 5);
        for (int i = 1; i < strobes.size(); i++) begin
            chk("rd_gap", strobes[i] - strobes[i-1], 2);
        end
        drain(1'b0);
        check_counts("burst");

        // Reset in the middle of a frame, then a clean frame
        frm = '{8'h03, 8'h10, 8'h20, 8'h30, 8'h63};
        send_frame();
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(posedge clk);
            #1;
            if (m_valid && m_data == 8'h10) found = 1'b1;
        end
        chk("mid_reached", found, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        fq.delete();
        exp_q.delete();
        exp_good  = 0;
        exp_err   = 0;
        exp_done  = 0;
        done_seen = 0;
        err_seen  = 0;
        @(posedge clk);
        #1;
        check_idle_zero("midreset");
        reset = 1'b0;
        frm = '{8'h01, 8'h7F, 8'h80};
        send_frame();
        drain(1'b0);
        check_counts("postreset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: got=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
